// File: rtl/clk_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_gen_ctrl
// Description : CPU clock control. A free-running divider feeds a run/step/halt
//               controller with a debounced single-step button. It drives a
//               one-cycle enable pulse, a toggling CPU clock and a pulse count.
//               Optional BURST mode is built when CLK_GEN_BURST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_gen_ctrl #(
    parameter int CNT_W     = 32,
    parameter int TAP_W     = 5,
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_mode,
    input  logic [TAP_W-1:0] i_tap,
    input  logic             i_step_btn,
`ifdef CLK_GEN_BURST_EN
    input  logic [7:0]       i_burst_len,
`endif
    output logic             o_clk_en,
    output logic             o_clk_cpu,
    output logic [31:0]      o_en_cnt
);

    localparam logic [1:0] c_MODE_RUN   = 2'b01;
    localparam logic [1:0] c_MODE_STEP  = 2'b10;
`ifdef CLK_GEN_BURST_EN
    localparam logic [1:0] c_MODE_BURST = 2'b11;
`endif

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_PRESS_WAIT = 3'd1;
    localparam logic [2:0] c_ST_PRESSED    = 3'd2;
    localparam logic [2:0] c_ST_HOLD       = 3'd3;
    localparam logic [2:0] c_ST_REL_WAIT   = 3'd4;

    localparam logic [TAP_W-1:0] c_TAP_MAX = TAP_W'(CNT_W - 1);
    localparam logic [DB_W-1:0]  c_DB_LAST = DB_W'(DB_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_mask;
    logic [TAP_W-1:0] w_tap_eff;
    logic             w_tick;

    logic             r_sync1;
    logic             r_btn_s;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [DB_W-1:0]  r_db;
    logic [DB_W-1:0]  w_db_nxt;
    logic [DB_W-1:0]  w_db_inc;
    logic             w_step_req;

    logic             w_en_nxt;
    logic             r_clk_en;
    logic             r_clk_cpu;
    logic [31:0]      r_en_cnt;

    // ------------------------------------------------------------------------
    // Free-running divider; tick when the low TAP_eff+1 bits are all ones.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_tap_eff = (i_tap > c_TAP_MAX) ? c_TAP_MAX : i_tap;

    genvar gi;
    generate
        for (gi = 0; gi < CNT_W; gi++) begin : g_mask
            assign w_mask[gi] = (TAP_W'(gi) <= w_tap_eff);
        end
    endgenerate

    assign w_tick = &(r_cnt | ~w_mask);

    // ------------------------------------------------------------------------
    // Button synchronizer
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sync1 <= i_step_btn;
            r_btn_s <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce FSM: state register, next-state logic, output decode
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
            r_db    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_db    <= w_db_nxt;
        end
    end

    assign w_db_inc = r_db + DB_W'(1);

    // r_db counts stable synced cycles including the one that entered the wait state.
    always_comb begin
        w_state_nxt = r_state;
        w_db_nxt    = r_db;
        case (r_state)
            c_ST_IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = c_ST_PRESS_WAIT;
                    w_db_nxt    = DB_W'(1);
                end
            end
            c_ST_PRESS_WAIT: begin
                if (r_btn_s) begin
                    w_db_nxt = w_db_inc;
                    if (w_db_inc == c_DB_LAST) begin
                        w_state_nxt = c_ST_PRESSED;
                    end
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_PRESSED: begin
                w_state_nxt = c_ST_HOLD;
            end
            c_ST_HOLD: begin
                if (!r_btn_s) begin
                    w_state_nxt = c_ST_REL_WAIT;
                    w_db_nxt    = DB_W'(1);
                end
            end
            c_ST_REL_WAIT: begin
                if (!r_btn_s) begin
                    w_db_nxt = w_db_inc;
                    if (w_db_inc == c_DB_LAST) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_db_nxt    = '0;
            end
        endcase
    end

    always_comb begin
        w_step_req = (r_state == c_ST_PRESSED);
    end

`ifdef CLK_GEN_BURST_EN
    // ------------------------------------------------------------------------
    // Burst remaining-pulse counter; a request is only accepted when idle.
    // ------------------------------------------------------------------------
    logic [7:0] r_rem;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rem <= 8'd0;
        end else if (i_mode != c_MODE_BURST) begin
            r_rem <= 8'd0;
        end else if (r_rem != 8'd0) begin
            if (w_tick) begin
                r_rem <= r_rem - 8'd1;
            end
        end else if (w_step_req) begin
            r_rem <= (i_burst_len == 8'd0) ? 8'd1 : i_burst_len;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Enable decision uses the MODE sampled in the same cycle as the tick/request.
    // ------------------------------------------------------------------------
    always_comb begin
        w_en_nxt = 1'b0;
        case (i_mode)
            c_MODE_RUN:   w_en_nxt = w_tick;
            c_MODE_STEP:  w_en_nxt = w_step_req;
`ifdef CLK_GEN_BURST_EN
            c_MODE_BURST: w_en_nxt = w_tick && (r_rem != 8'd0);
`endif
            default:      w_en_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_en  <= 1'b0;
            r_clk_cpu <= 1'b0;
            r_en_cnt  <= 32'd0;
        end else begin
            r_clk_en <= w_en_nxt;
            if (r_clk_en) begin
                r_clk_cpu <= ~r_clk_cpu;
                r_en_cnt  <= r_en_cnt + 32'd1;
            end
        end
    end

    assign o_clk_en  = r_clk_en;
    assign o_clk_cpu = r_clk_cpu;
    assign o_en_cnt  = r_en_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_gen_ctrl
// Description : Scoreboard bench for clk_gen_ctrl with a run-length button model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_gen_ctrl;

    localparam int CNT_W = 8;
    localparam int TAP_W = 4;
    localparam int DB    = 4;
    localparam int DB_W  = 3;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             btn   = 1'b0;
    logic [1:0]       mode  = 2'b00;
    logic [TAP_W-1:0] tap   = '0;
    logic [7:0]       burst_len = 8'd0;
    logic             clk_en;
    logic             clk_cpu;
    logic [31:0]      en_cnt;

    always #5 clk = ~clk;

    clk_gen_ctrl #(
        .CNT_W(CNT_W), .TAP_W(TAP_W), .DB_CYCLES(DB), .DB_W(DB_W)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_mode     (mode),
        .i_tap      (tap),
        .i_step_btn (btn),
`ifdef CLK_GEN_BURST_EN
        .i_burst_len(burst_len),
`endif
        .o_clk_en   (clk_en),
        .o_clk_cpu  (clk_cpu),
        .o_en_cnt   (en_cnt)
    );

    typedef struct {
        int unsigned cyc;
        logic [31:0] en;
        logic        cpu;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: divider as modular arithmetic, button as run lengths of the synced level.
    int unsigned m_cnt, run0, run1, per, rem;
    logic        m_s1, m_s2, armed, blind, fire, fire_now, tick, p, m_pulse, m_cpu;
    logic [31:0] m_en;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_cnt = 0; run0 = 0; run1 = 0; rem = 0;
                m_s1 = 0; m_s2 = 0; armed = 1; blind = 0; fire = 0;
                m_pulse = 0; m_cpu = 0; m_en = 0;
            end else begin
                if (m_pulse) begin
                    m_en  = m_en + 1;
                    m_cpu = ~m_cpu;
                end
                per  = 1 << ((tap > 7) ? 8 : (int'(tap) + 1));
                tick = ((m_cnt % per) == per - 1);
                fire_now = fire;
                p = 0;
                case (mode)
                    2'b01: p = tick;
                    2'b10: p = fire_now;
                    default: p = 0;
                endcase
`ifdef CLK_GEN_BURST_EN
                if (mode == 2'b11) begin
                    if (rem != 0) begin
                        if (tick) begin
                            p = 1;
                            rem--;
                        end
                    end else if (fire_now) begin
                        rem = (burst_len == 0) ? 1 : burst_len;
                    end
                end else begin
                    rem = 0;
                end
`endif
                fire = 0;
                if (blind) begin
                    blind = 0; run0 = 0; run1 = 0;
                end else if (m_s2) begin
                    run1++; run0 = 0;
                    if (armed && run1 == DB) begin
                        fire = 1; armed = 0; blind = 1;
                    end
                end else begin
                    run0++; run1 = 0;
                    if (!armed && run0 == DB) armed = 1;
                end
                m_s2 = m_s1;
                m_s1 = btn;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_pulse = p;
                if (p) q.push_back('{cyc, m_en, m_cpu});
            end
        end
    end

    // Monitor: every observed enable pulse is matched against the scoreboard.
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (clk_en === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_en", {31'b0, clk_en}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("en_cycle", cyc, e.cyc);
                    check("en_cnt_at_pulse", en_cnt, e.en);
                    check("clk_cpu_at_pulse", {31'b0, clk_cpu}, {31'b0, e.cpu});
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                check("missing_en", {31'b0, clk_en}, 32'd1);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_en_cnt"}, en_cnt, m_en);
        check({tag, "_clk_cpu"}, {31'b0, clk_cpu}, {31'b0, m_cpu});
    endtask

    logic [31:0] base;
    logic        cpu0;
    int          first, pulses;
    logic        b_pat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        // Reset held with RUN selected
        rst_n = 1'b0; mode = 2'b01; tap = '0; btn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_clk_en", {31'b0, clk_en}, 32'd0);
            check("rst_clk_cpu", {31'b0, clk_cpu}, 32'd0);
            check("rst_en_cnt", en_cnt, 32'd0);
        end
        rst_n = 1'b1;
        first = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (clk_en && first == 0) first = i;
        end
        check("rst_first_en_latency", first, 2);

        // RUN at TAP=2, then clamped TAP=9
        mode = 2'b00; tap = 4'd2; wait_cyc(4);
        base = en_cnt; mode = 2'b01; wait_cyc(64); mode = 2'b00; wait_cyc(3);
        check("run_tap2_pulses", en_cnt - base, 32'd8);
        check_model("run_tap2");
        tap = 4'd9; base = en_cnt; mode = 2'b01; wait_cyc(512); mode = 2'b00; wait_cyc(3);
        check("run_tap9_pulses", en_cnt - base, 32'd2);

        // STEP single press
        mode = 2'b10; wait_cyc(2);
        base = en_cnt; btn = 1'b1; first = 0; pulses = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (clk_en) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i == 10) btn = 1'b0;
        end
        check("step_latency", first, 7);
        check("step_pulses", pulses, 1);
        check("step_en_cnt", en_cnt - base, 32'd1);

        // STEP bounce, then hold/release/press
        base = en_cnt;
        for (int i = 0; i < 6; i++) begin
            btn = b_pat[i];
            wait_cyc(1);
        end
        btn = 1'b0; wait_cyc(10);
        check("bounce_no_pulse", en_cnt - base, 32'd0);
        btn = 1'b1; wait_cyc(20);
        btn = 1'b0; wait_cyc(10);
        btn = 1'b1; wait_cyc(10);
        btn = 1'b0; wait_cyc(10);
        check("hold_release_press", en_cnt - base, 32'd2);
        check_model("step");

        // HALT mid-RUN, press during HALT
        tap = 4'd0; mode = 2'b01; wait_cyc(10);
        mode = 2'b00; wait_cyc(2);
        base = en_cnt; cpu0 = clk_cpu; wait_cyc(20);
        check("halt_en_cnt_frozen", en_cnt, base);
        check("halt_clk_cpu_frozen", {31'b0, clk_cpu}, {31'b0, cpu0});
        btn = 1'b1; wait_cyc(10); btn = 1'b0; wait_cyc(10);
        mode = 2'b10; wait_cyc(10);
        check("halt_press_discarded", en_cnt - base, 32'd0);

`ifdef CLK_GEN_BURST_EN
        mode = 2'b11; tap = 4'd1; burst_len = 8'd3; wait_cyc(2);
        base = en_cnt;
        btn = 1'b1; wait_cyc(8); btn = 1'b0; wait_cyc(30);
        check("burst_len3", en_cnt - base, 32'd3);
        tap = 4'd3; base = en_cnt;
        btn = 1'b1; wait_cyc(8); btn = 1'b0; wait_cyc(8);
        btn = 1'b1; wait_cyc(8); btn = 1'b0; wait_cyc(60);
        check("burst_second_press_ignored", en_cnt - base, 32'd3);
        tap = 4'd1; burst_len = 8'd0; base = en_cnt;
        btn = 1'b1; wait_cyc(8); btn = 1'b0; wait_cyc(20);
        check("burst_len0", en_cnt - base, 32'd1);
`endif

        // Randomized modes, taps and button activity
        for (int seg = 0; seg < 150; seg++) begin
            mode = 2'($urandom_range(0, 3));
            tap  = 4'($urandom_range(0, 9));
            burst_len = 8'($urandom_range(0, 4));
            for (int i = 0; i < int'($urandom_range(3, 20)); i++) begin
                @(negedge clk);
                if ($urandom_range(0, 5) == 0) btn = ~btn;
            end
        end

        mode = 2'b00; btn = 1'b0; wait_cyc(20);
        check("queue_drained", q.size(), 32'd0);
        check_model("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
